multi_vault_safe_ctrl: RTL and testbench

//  Parametrised successor to the single-safe bank top. Controls NUM_VAULTS independent safes,

---
 rtl/multi_vault_safe_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_multi_vault_safe_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_vault_safe_ctrl.sv
// Multi-vault safe controller: shared authorisation, per-vault PINs,
// attempt lockout, auto-close timers and timed PIN change.
module multi_vault_safe_ctrl #(
   parameter int NUM_VAULTS = 4,
   parameter int PIN_WIDTH = 4,
   parameter int NUM_OFFICERS = 2,
   parameter int QUORUM = 2,
   parameter logic [PIN_WIDTH-1:0] DEFAULT_PIN = '0,
   parameter int MAX_ATTEMPTS = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int OPEN_TIMEOUT = 5000,
   parameter int PINCHG_TIMEOUT = 2000,
   parameter int INVALID_HOLD = 500,
   localparam int VSEL_W = (NUM_VAULTS > 1) ? $clog2(NUM_VAULTS) : 1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    BankTiming,
   input  logic                    GaurdAvailability,
   input  logic                    PresidentAuthenticated,
   input  logic [NUM_OFFICERS-1:0] OfficerAuthenticated,
   input  logic [VSEL_W-1:0]       VaultSelect,
   input  logic [PIN_WIDTH-1:0]    UserPINRead,
   input  logic                    OpenClosePush,
   input  logic                    PINChangePush,
   output logic [NUM_VAULTS-1:0]   SafeStatus,
   output logic                    VaultStatus,
   output logic                    InvalidLED,
   output logic                    LockoutLED,
   output logic [1:0]              CurrentState,
   output logic [PIN_WIDTH-1:0]    PINStored
);

   localparam int OC_W = $clog2(NUM_OFFICERS + 1);
   localparam int AT_W = (MAX_ATTEMPTS > 0) ? $clog2(MAX_ATTEMPTS + 1) : 1;
   localparam int LK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
   localparam int OT_W = (OPEN_TIMEOUT > 0) ? $clog2(OPEN_TIMEOUT + 1) : 1;
   localparam int PC_W = (PINCHG_TIMEOUT > 0) ? $clog2(PINCHG_TIMEOUT + 1) : 1;
   localparam int IH_W = (INVALID_HOLD > 0) ? $clog2(INVALID_HOLD + 1) : 1;

   localparam logic [OC_W-1:0] QUORUM_C = OC_W'(QUORUM);
   localparam logic [AT_W-1:0] AT_MAX = AT_W'(MAX_ATTEMPTS);
   localparam logic [AT_W-1:0] AT_ONE = AT_W'(1);
   localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES);
   localparam logic [LK_W-1:0] LK_ONE = LK_W'(1);
   localparam logic [OT_W-1:0] OT_LOAD = OT_W'(OPEN_TIMEOUT);
   localparam logic [OT_W-1:0] OT_ONE = OT_W'(1);
   localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PINCHG_TIMEOUT);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
   localparam logic [IH_W-1:0] IH_LOAD = IH_W'(INVALID_HOLD);
   localparam logic [IH_W-1:0] IH_ONE = IH_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PINCHG = 2'd1,
      ST_LOCK   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  vs_q, vs_d;
   logic                  oc_q, pc_q;
   logic [NUM_VAULTS-1:0] safe_q, safe_d;
   logic [PIN_WIDTH-1:0]  pin_q [NUM_VAULTS];
   logic [PIN_WIDTH-1:0]  pin_d [NUM_VAULTS];
   logic [AT_W-1:0]       att_q [NUM_VAULTS];
   logic [AT_W-1:0]       att_d [NUM_VAULTS];
   logic [OT_W-1:0]       otmr_q [NUM_VAULTS];
   logic [OT_W-1:0]       otmr_d [NUM_VAULTS];
   logic [LK_W-1:0]       lk_q, lk_d;
   logic [PC_W-1:0]       pct_q, pct_d;
   logic [IH_W-1:0]       inv_q, inv_d;
   logic [VSEL_W-1:0]     lat_q, lat_d;
   logic [VSEL_W-1:0]     lkv_q, lkv_d;
   logic [OC_W-1:0]       ocnt;
   logic                  oc_evt, pc_evt;
   logic                  sel_ok;
   logic                  rej;

   assign oc_evt = OpenClosePush & ~oc_q;
   assign pc_evt = PINChangePush & ~pc_q;
   assign sel_ok = (int'(VaultSelect) < NUM_VAULTS);

   // Count authenticated officers for the quorum check
   always_comb begin
      ocnt = '0;
      for (int i = 0; i < NUM_OFFICERS; i++) begin
         ocnt = ocnt + OC_W'(OfficerAuthenticated[i]);
      end
   end

   assign vs_d = BankTiming & GaurdAvailability &
                 (PresidentAuthenticated | (ocnt >= QUORUM_C));

   // Next-state: timers, push handling per FSM state, de-authorisation
   always_comb begin
      state_d = state_q;
      safe_d  = safe_q;
      pin_d   = pin_q;
      att_d   = att_q;
      otmr_d  = otmr_q;
      lk_d    = lk_q;
      pct_d   = pct_q;
      lat_d   = lat_q;
      lkv_d   = lkv_q;
      rej     = 1'b0;

      if (OPEN_TIMEOUT > 0) begin
         for (int v = 0; v < NUM_VAULTS; v++) begin
            if (safe_q[v]) begin
               if (otmr_q[v] <= OT_ONE) begin
                  otmr_d[v] = '0;
                  safe_d[v] = 1'b0;
               end else begin
                  otmr_d[v] = otmr_q[v] - OT_ONE;
               end
            end
         end
      end

      if (!vs_q) begin
         safe_d = '0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (vs_q && (oc_evt || pc_evt)) begin
               if (!sel_ok) begin
                  rej = 1'b1;
               end else if (oc_evt) begin
                  if (safe_q[VaultSelect]) begin
                     safe_d[VaultSelect] = 1'b0;
                  end else if (UserPINRead == pin_q[VaultSelect]) begin
                     safe_d[VaultSelect] = 1'b1;
                     att_d[VaultSelect]  = '0;
                     otmr_d[VaultSelect] = OT_LOAD;
                  end else begin
                     rej = 1'b1;
                     if (att_q[VaultSelect] != AT_MAX) begin
                        att_d[VaultSelect] = att_q[VaultSelect] + AT_ONE;
                     end
                     if (att_d[VaultSelect] >= AT_MAX) begin
                        state_d = ST_LOCK;
                        lk_d    = LK_LOAD;
                        lkv_d   = VaultSelect;
                     end
                  end
               end else if (safe_q[VaultSelect]) begin
                  state_d = ST_PINCHG;
                  lat_d   = VaultSelect;
                  pct_d   = PC_LOAD;
               end else begin
                  rej = 1'b1;
               end
            end
         end
         ST_PINCHG: begin
            if (!vs_q) begin
               state_d = ST_IDLE;
               pct_d   = '0;
            end else if (oc_evt) begin
               pin_d[lat_q] = UserPINRead;
               state_d      = ST_IDLE;
               pct_d        = '0;
            end else if (pc_evt) begin
               state_d = ST_IDLE;
               pct_d   = '0;
            end else if (pct_q <= PC_ONE || !safe_d[lat_q]) begin
               rej     = 1'b1;
               state_d = ST_IDLE;
               pct_d   = '0;
            end else begin
               pct_d = pct_q - PC_ONE;
            end
         end
         ST_LOCK: begin
            if (lk_q <= LK_ONE) begin
               lk_d         = '0;
               state_d      = ST_IDLE;
               att_d[lkv_q] = '0;
            end else begin
               lk_d = lk_q - LK_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Rejection hold counter: reload on reject, otherwise count down to 0
   always_comb begin
      inv_d = inv_q;
      if (rej) begin
         inv_d = IH_LOAD;
      end else if (inv_q != '0) begin
         inv_d = inv_q - IH_ONE;
      end
   end

   // State and datapath registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         vs_q    <= 1'b0;
         oc_q    <= 1'b0;
         pc_q    <= 1'b0;
         safe_q  <= '0;
         lk_q    <= '0;
         pct_q   <= '0;
         inv_q   <= '0;
         lat_q   <= '0;
         lkv_q   <= '0;
         for (int v = 0; v < NUM_VAULTS; v++) begin
            pin_q[v]  <= DEFAULT_PIN;
            att_q[v]  <= '0;
            otmr_q[v] <= '0;
         end
      end else begin
         state_q <= state_d;
         vs_q    <= vs_d;
         oc_q    <= OpenClosePush;
         pc_q    <= PINChangePush;
         safe_q  <= safe_d;
         lk_q    <= lk_d;
         pct_q   <= pct_d;
         inv_q   <= inv_d;
         lat_q   <= lat_d;
         lkv_q   <= lkv_d;
         pin_q   <= pin_d;
         att_q   <= att_d;
         otmr_q  <= otmr_d;
      end
   end

   // Debug view of the selected vault's PIN
   always_comb begin
      PINStored = '0;
      if (sel_ok) begin
         PINStored = pin_q[VaultSelect];
      end
   end

   assign SafeStatus   = safe_q;
   assign VaultStatus  = vs_q;
   assign InvalidLED   = (inv_q != '0);
   assign LockoutLED   = (state_q == ST_LOCK);
   assign CurrentState = state_q;

endmodule

// File: tb/tb_multi_vault_safe_ctrl.sv
// Bench for multi_vault_safe_ctrl: timestamp-based reference model,
// per-cycle output compare and directed literal checks.
module tb_multi_vault_safe_ctrl;

   localparam int NV = 5;
   localparam int PW = 4;
   localparam int NO = 2;
   localparam int QU = 2;
   localparam int MAXA = 3;
   localparam int LK = 1000;
   localparam int OT = 8;
   localparam int PCT = 2000;
   localparam int IH = 500;
   localparam int VW = $clog2(NV);

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          BankTiming = 1'b0;
   logic          GaurdAvailability = 1'b0;
   logic          PresidentAuthenticated = 1'b0;
   logic [NO-1:0] OfficerAuthenticated = '0;
   logic [VW-1:0] VaultSelect = '0;
   logic [PW-1:0] UserPINRead = '0;
   logic          OpenClosePush = 1'b0;
   logic          PINChangePush = 1'b0;
   logic [NV-1:0] SafeStatus;
   logic          VaultStatus;
   logic          InvalidLED;
   logic          LockoutLED;
   logic [1:0]    CurrentState;
   logic [PW-1:0] PINStored;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   multi_vault_safe_ctrl #(
      .NUM_VAULTS(NV),
      .PIN_WIDTH(PW),
      .NUM_OFFICERS(NO),
      .QUORUM(QU),
      .DEFAULT_PIN(4'h0),
      .MAX_ATTEMPTS(MAXA),
      .LOCKOUT_CYCLES(LK),
      .OPEN_TIMEOUT(OT),
      .PINCHG_TIMEOUT(PCT),
      .INVALID_HOLD(IH)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .BankTiming(BankTiming),
      .GaurdAvailability(GaurdAvailability),
      .PresidentAuthenticated(PresidentAuthenticated),
      .OfficerAuthenticated(OfficerAuthenticated),
      .VaultSelect(VaultSelect),
      .UserPINRead(UserPINRead),
      .OpenClosePush(OpenClosePush),
      .PINChangePush(PINChangePush),
      .SafeStatus(SafeStatus),
      .VaultStatus(VaultStatus),
      .InvalidLED(InvalidLED),
      .LockoutLED(LockoutLED),
      .CurrentState(CurrentState),
      .PINStored(PINStored)
   );

   // Reference model: deadlines kept as absolute edge numbers
   logic [PW-1:0] m_pin [NV];
   bit            m_open [NV];
   int            m_close_at [NV];
   int            m_att [NV];
   int            m_state = 0;
   int            m_lock_end = 0;
   int            m_lockv = 0;
   int            m_pc_end = 0;
   int            m_lat = 0;
   int            m_inv_until = 0;
   int            cyc = 0;
   bit            m_vs = 0;
   bit            m_poc = 0;
   bit            m_ppc = 0;

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         m_pin[v] = 4'h0;
         m_open[v] = 0;
         m_close_at[v] = 0;
         m_att[v] = 0;
      end
      m_state = 0;
      m_inv_until = 0;
      m_vs = 0;
      m_poc = 0;
      m_ppc = 0;
   endtask

   task automatic model_step();
      bit oc, pc, rej, auth;
      bit nopen [NV];
      int s;
      cyc++;
      oc = OpenClosePush && !m_poc;
      pc = PINChangePush && !m_ppc;
      auth = m_vs;
      rej = 0;
      for (int v = 0; v < NV; v++) begin
         nopen[v] = m_open[v] && auth && (OT == 0 || m_close_at[v] != cyc);
      end
      s = int'(VaultSelect);
      case (m_state)
         0: begin
            if (auth && (oc || pc)) begin
               if (s >= NV) begin
                  rej = 1;
               end else if (oc) begin
                  if (m_open[s]) begin
                     nopen[s] = 0;
                  end else if (UserPINRead == m_pin[s]) begin
                     nopen[s] = 1;
                     m_att[s] = 0;
                     m_close_at[s] = cyc + OT;
                  end else begin
                     rej = 1;
                     m_att[s]++;
                     if (m_att[s] >= MAXA) begin
                        m_state = 2;
                        m_lock_end = cyc + LK;
                        m_lockv = s;
                     end
                  end
               end else if (m_open[s]) begin
                  m_state = 1;
                  m_lat = s;
                  m_pc_end = cyc + PCT;
               end else begin
                  rej = 1;
               end
            end
         end
         1: begin
            if (!auth) begin
               m_state = 0;
            end else if (oc) begin
               m_pin[m_lat] = UserPINRead;
               m_state = 0;
            end else if (pc) begin
               m_state = 0;
            end else if (cyc >= m_pc_end || !nopen[m_lat]) begin
               rej = 1;
               m_state = 0;
            end
         end
         default: begin
            if (cyc >= m_lock_end) begin
               m_state = 0;
               m_att[m_lockv] = 0;
            end
         end
      endcase
      if (rej) m_inv_until = cyc + IH;
      m_open = nopen;
      m_vs = BankTiming && GaurdAvailability &&
             (PresidentAuthenticated || $countones(OfficerAuthenticated) >= QU);
      m_poc = OpenClosePush;
      m_ppc = PINChangePush;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge Clk or negedge Reset);
         if (!Reset) model_reset();
         else model_step();
      end
   end

   task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_safe();
      logic [31:0] r;
      r = '0;
      for (int v = 0; v < NV; v++) r[v] = m_open[v];
      return r;
   endfunction

   function automatic logic [31:0] exp_pin();
      logic [31:0] r;
      r = '0;
      if (int'(VaultSelect) < NV) r = 32'(m_pin[int'(VaultSelect)]);
      return r;
   endfunction

   // Every falling edge: DUT outputs against the model
   initial begin
      forever begin
         @(negedge Clk);
         cmp("m_SafeStatus", 32'(SafeStatus), exp_safe());
         cmp("m_VaultStatus", 32'(VaultStatus), 32'(m_vs));
         cmp("m_InvalidLED", 32'(InvalidLED), 32'(cyc < m_inv_until));
         cmp("m_LockoutLED", 32'(LockoutLED), 32'(m_state == 2));
         cmp("m_CurrentState", 32'(CurrentState), 32'(m_state));
         cmp("m_PINStored", 32'(PINStored), exp_pin());
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(negedge Clk);
         #1;
      end
   endtask

   task automatic push_oc(int v, logic [PW-1:0] p);
      VaultSelect = VW'(v);
      UserPINRead = p;
      OpenClosePush = 1'b1;
      tick(1);
      OpenClosePush = 1'b0;
      tick(1);
   endtask

   task automatic push_pc(int v);
      VaultSelect = VW'(v);
      PINChangePush = 1'b1;
      tick(1);
      PINChangePush = 1'b0;
      tick(1);
   endtask

   initial begin
      tick(2);
      cmp("rst_safe", 32'(SafeStatus), 32'h0);
      cmp("rst_vs", 32'(VaultStatus), 32'h0);
      cmp("rst_state", 32'(CurrentState), 32'h0);
      cmp("rst_leds", 32'({InvalidLED, LockoutLED}), 32'h0);
      cmp("rst_pin", 32'(PINStored), 32'h0);
      Reset = 1'b1;

      // T1 authorisation quorum
      BankTiming = 1'b1;
      GaurdAvailability = 1'b1;
      OfficerAuthenticated = 2'b01;
      tick(2);
      cmp("t1_one_officer", 32'(VaultStatus), 32'h0);
      OfficerAuthenticated = 2'b11;
      tick(1);
      cmp("t1_quorum", 32'(VaultStatus), 32'h1);

      // T2 open / close vault 2, hold does not retrigger
      push_oc(2, 4'h0);
      cmp("t2_open", 32'(SafeStatus), 32'h04);
      push_oc(2, 4'h0);
      cmp("t2_close", 32'(SafeStatus), 32'h00);
      VaultSelect = 3'd2;
      OpenClosePush = 1'b1;
      tick(3);
      cmp("t2_hold", 32'(SafeStatus), 32'h04);
      OpenClosePush = 1'b0;
      tick(1);
      push_oc(2, 4'h0);
      cmp("t2_close2", 32'(SafeStatus), 32'h00);

      // Auto-close 8 cycles after opening
      push_oc(1, 4'h0);
      tick(6);
      cmp("t6_to_open", 32'(SafeStatus), 32'h02);
      tick(1);
      cmp("t6_to_closed", 32'(SafeStatus), 32'h00);

      // T3 lockout on vault 1
      push_oc(1, 4'h5);
      push_oc(1, 4'h5);
      cmp("t3_two_wrong", 32'(CurrentState), 32'h0);
      push_oc(1, 4'h5);
      cmp("t3_inv", 32'(InvalidLED), 32'h1);
      cmp("t3_lockled", 32'(LockoutLED), 32'h1);
      cmp("t3_state", 32'(CurrentState), 32'h2);
      push_oc(0, 4'h0);
      cmp("t3_ignored", 32'(SafeStatus), 32'h00);
      tick(996);
      cmp("t3_still_locked", 32'(CurrentState), 32'h2);
      tick(1);
      cmp("t3_unlocked", 32'(CurrentState), 32'h0);
      push_oc(1, 4'h5);
      push_oc(1, 4'h5);
      cmp("t3_att_cleared", 32'(CurrentState), 32'h0);
      push_oc(1, 4'h0);
      cmp("t3_reopen", 32'(SafeStatus), 32'h02);
      push_oc(1, 4'h0);

      // T4 PIN change on vault 0
      push_oc(0, 4'h0);
      push_pc(0);
      cmp("t4_pinchg", 32'(CurrentState), 32'h1);
      push_oc(0, 4'hA);
      cmp("t4_pinstored", 32'(PINStored), 32'hA);
      cmp("t4_idle", 32'(CurrentState), 32'h0);
      push_oc(0, 4'hA);
      push_oc(0, 4'h0);
      cmp("t4_old_rejected", 32'(SafeStatus), 32'h00);
      cmp("t4_old_inv", 32'(InvalidLED), 32'h1);
      push_oc(0, 4'hA);
      cmp("t4_new_ok", 32'(SafeStatus), 32'h01);
      push_oc(0, 4'hA);

      // T5 de-authorisation
      push_oc(0, 4'hA);
      push_oc(3, 4'h0);
      push_pc(3);
      cmp("t5_pinchg", 32'(CurrentState), 32'h1);
      BankTiming = 1'b0;
      tick(2);
      cmp("t5_closed", 32'(SafeStatus), 32'h00);
      cmp("t5_abort", 32'(CurrentState), 32'h0);
      push_oc(2, 4'h0);
      cmp("t5_ignored", 32'(SafeStatus), 32'h00);
      BankTiming = 1'b1;
      tick(2);

      // T6 simultaneous pushes: OpenClose wins
      push_oc(2, 4'h0);
      VaultSelect = 3'd2;
      OpenClosePush = 1'b1;
      PINChangePush = 1'b1;
      tick(1);
      OpenClosePush = 1'b0;
      PINChangePush = 1'b0;
      tick(1);
      cmp("t6_both_safe", 32'(SafeStatus), 32'h00);
      cmp("t6_both_state", 32'(CurrentState), 32'h0);

      // T6 out-of-range select
      tick(IH + 10);
      cmp("t6_led_off", 32'(InvalidLED), 32'h0);
      push_oc(6, 4'h0);
      cmp("t6_oor_inv", 32'(InvalidLED), 32'h1);
      cmp("t6_oor_state", 32'(CurrentState), 32'h0);
      cmp("t6_oor_pin", 32'(PINStored), 32'h0);

      // PIN change abandoned when the vault auto-closes
      push_oc(4, 4'h0);
      push_pc(4);
      tick(4);
      cmp("t6_pc_wait", 32'(CurrentState), 32'h1);
      tick(1);
      cmp("t6_pc_abandon", 32'(CurrentState), 32'h0);
      cmp("t6_pc_closed", 32'(SafeStatus), 32'h00);

      // PIN change aborted by a second PINChange
      push_oc(4, 4'h0);
      push_pc(4);
      push_pc(4);
      cmp("t6_pc_abort", 32'(CurrentState), 32'h0);
      cmp("t6_pc_pin", 32'(PINStored), 32'h0);
      tick(8);

      // Reset pulse mid-PINCHG
      push_oc(0, 4'hA);
      push_pc(0);
      cmp("t6_rst_pre", 32'(CurrentState), 32'h1);
      Reset = 1'b0;
      #2;
      cmp("t6_rst_state", 32'(CurrentState), 32'h0);
      cmp("t6_rst_safe", 32'(SafeStatus), 32'h00);
      cmp("t6_rst_vs", 32'(VaultStatus), 32'h0);
      cmp("t6_rst_pin", 32'(PINStored), 32'h0);
      tick(1);
      Reset = 1'b1;
      tick(2);
      push_oc(0, 4'h0);
      cmp("t6_rst_default_pin", 32'(SafeStatus), 32'h01);
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
